// File: rtl/riscv_i32_debug_issue_if.sv
// Debug-access bundle: abstract-command request/response plus the debug
// instruction channel toward the pipeline and its ack/result return path.
interface riscv_i32_debug_issue_if;
    logic        dbg_req_valid;
    logic        dbg_req_ready;
    logic        dbg_req_write;
    logic        dbg_req_is_gpr;
    logic [11:0] dbg_req_address;
    logic [31:0] dbg_req_data;

    logic        dbg_resp_valid;
    logic        dbg_resp_ready;
    logic [31:0] dbg_resp_data;
    logic        dbg_resp_error;

    logic        instruction__debug__valid;
    logic [1:0]  instruction__debug__debug_op;
    logic [15:0] instruction__debug__data;
    logic [31:0] instruction__data;

    logic        pipeline_debug_ack;
    logic        pipeline_result_valid;
    logic [31:0] pipeline_result_data;

    // Sequencer side: initiates debug instructions, answers debug requests.
    modport master (
        input  dbg_req_valid, dbg_req_write, dbg_req_is_gpr, dbg_req_address, dbg_req_data,
        output dbg_req_ready,
        output dbg_resp_valid, dbg_resp_data, dbg_resp_error,
        input  dbg_resp_ready,
        output instruction__debug__valid, instruction__debug__debug_op,
        output instruction__debug__data, instruction__data,
        input  pipeline_debug_ack, pipeline_result_valid, pipeline_result_data
    );

    // Environment side: debug module plus pipeline.
    modport slave (
        output dbg_req_valid, dbg_req_write, dbg_req_is_gpr, dbg_req_address, dbg_req_data,
        input  dbg_req_ready,
        input  dbg_resp_valid, dbg_resp_data, dbg_resp_error,
        output dbg_resp_ready,
        input  instruction__debug__valid, instruction__debug__debug_op,
        input  instruction__debug__data, instruction__data,
        output pipeline_debug_ack, pipeline_result_valid, pipeline_result_data
    );
endinterface

// File: rtl/riscv_i32_debug_issue.sv
// Debug access sequencer: turns one GPR/CSR request into a debug instruction,
// waits for the pipeline to finish (or time out) and returns one response.
module riscv_i32_debug_issue #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           riscv_config__e32,
    riscv_i32_debug_issue_if.master        bus
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_WAIT    = 2'd2,
        S_RESPOND = 2'd3
    } state_e;

    localparam logic [7:0] TIMEOUT_LIMIT = TIMEOUT_CYCLES[7:0];

    state_e      state_q, state_d;
    logic [7:0]  timer_q, timer_d;
    logic        write_q, write_d;
    logic        req_ready_q, req_ready_d;
    logic        instr_valid_q, instr_valid_d;
    logic [1:0]  instr_op_q, instr_op_d;
    logic [15:0] instr_dbg_data_q, instr_dbg_data_d;
    logic [31:0] instr_data_q, instr_data_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_data_q, resp_data_d;
    logic        resp_error_q, resp_error_d;

    logic req_fire;
    logic req_illegal;
    logic timed_out;
    logic result_taken;

    assign req_fire    = bus.dbg_req_valid & req_ready_q;
    // GPR numbers are 5 bits; RV32E additionally drops x16..x31.
    assign req_illegal = bus.dbg_req_is_gpr &
                         ((riscv_config__e32 & bus.dbg_req_address[4]) |
                          (bus.dbg_req_address[11:5] != 7'd0));
    // Timer reaches the limit at the start of the last permitted cycle.
    assign timed_out   = (timer_q == TIMEOUT_LIMIT);
    // A result only counts once the instruction has been accepted.
    assign result_taken = bus.pipeline_result_valid &
                          ((state_q == S_WAIT) ||
                           (state_q == S_ISSUE && bus.pipeline_debug_ack));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (req_fire) begin
                    state_d = req_illegal ? S_RESPOND : S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (result_taken || timed_out) begin
                    state_d = S_RESPOND;
                end else if (bus.pipeline_debug_ack) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (result_taken || timed_out) begin
                    state_d = S_RESPOND;
                end
            end
            S_RESPOND: begin
                if (bus.dbg_resp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        timer_d          = timer_q;
        write_d          = write_q;
        instr_valid_d    = instr_valid_q;
        instr_op_d       = instr_op_q;
        instr_dbg_data_d = instr_dbg_data_q;
        instr_data_d     = instr_data_q;
        resp_valid_d     = resp_valid_q;
        resp_data_d      = resp_data_q;
        resp_error_d     = resp_error_q;

        unique case (state_q)
            S_IDLE: begin
                if (req_fire) begin
                    write_d = bus.dbg_req_write;
                    if (req_illegal) begin
                        resp_valid_d = 1'b1;
                        resp_error_d = 1'b1;
                        resp_data_d  = 32'd0;
                    end else begin
                        instr_valid_d    = 1'b1;
                        instr_op_d       = {1'b0, bus.dbg_req_write};
                        instr_dbg_data_d = bus.dbg_req_is_gpr ?
                                           {3'b000, 1'b1, 7'd0, bus.dbg_req_address[4:0]} :
                                           {3'b000, 1'b0, bus.dbg_req_address};
                        instr_data_d     = bus.dbg_req_write ? bus.dbg_req_data : 32'd0;
                        timer_d          = 8'd0;
                    end
                end
            end
            S_ISSUE, S_WAIT: begin
                timer_d = timer_q + 8'd1;
                if (bus.pipeline_debug_ack || timed_out) begin
                    instr_valid_d = 1'b0;
                end
                // A result in the timeout cycle still wins over the error.
                if (result_taken) begin
                    instr_valid_d = 1'b0;
                    resp_valid_d  = 1'b1;
                    resp_error_d  = 1'b0;
                    resp_data_d   = write_q ? 32'd0 : bus.pipeline_result_data;
                end else if (timed_out) begin
                    resp_valid_d = 1'b1;
                    resp_error_d = 1'b1;
                    resp_data_d  = 32'd0;
                end
            end
            S_RESPOND: begin
                if (bus.dbg_resp_ready) begin
                    resp_valid_d = 1'b0;
                    resp_error_d = 1'b0;
                    resp_data_d  = 32'd0;
                end
            end
            default: ;
        endcase
    end

    assign req_ready_d = (state_d == S_IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            timer_q          <= 8'd0;
            write_q          <= 1'b0;
            req_ready_q      <= 1'b1;
            instr_valid_q    <= 1'b0;
            instr_op_q       <= 2'd0;
            instr_dbg_data_q <= 16'd0;
            instr_data_q     <= 32'd0;
            resp_valid_q     <= 1'b0;
            resp_data_q      <= 32'd0;
            resp_error_q     <= 1'b0;
        end else begin
            timer_q          <= timer_d;
            write_q          <= write_d;
            req_ready_q      <= req_ready_d;
            instr_valid_q    <= instr_valid_d;
            instr_op_q       <= instr_op_d;
            instr_dbg_data_q <= instr_dbg_data_d;
            instr_data_q     <= instr_data_d;
            resp_valid_q     <= resp_valid_d;
            resp_data_q      <= resp_data_d;
            resp_error_q     <= resp_error_d;
        end
    end

    assign bus.dbg_req_ready                = req_ready_q;
    assign bus.dbg_resp_valid               = resp_valid_q;
    assign bus.dbg_resp_data                = resp_data_q;
    assign bus.dbg_resp_error               = resp_error_q;
    assign bus.instruction__debug__valid    = instr_valid_q;
    assign bus.instruction__debug__debug_op = instr_op_q;
    assign bus.instruction__debug__data     = instr_dbg_data_q;
    assign bus.instruction__data            = instr_data_q;

endmodule

// File: tb/tb_riscv_i32_debug_issue.sv
// Self-checking bench for riscv_i32_debug_issue: directed table, reset and
// stray-result sequences, then randomized transactions against a cycle model.
module tb_riscv_i32_debug_issue;

    localparam int TO    = 8;
    localparam int NEVER = 99;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    logic e32     = 1'b0;

    riscv_i32_debug_issue_if bus ();

    riscv_i32_debug_issue #(.TIMEOUT_CYCLES(TO)) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .riscv_config__e32 (e32),
        .bus               (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        e32;
        logic        write;
        logic        is_gpr;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;     // value the pipeline returns
        int          ack_cyc;   // cycle after handshake in which ack is driven
        int          res_cyc;   // cycle after handshake in which result is driven
        int          bp;        // cycles of response back-pressure
        int          exp_d;     // cycle in which the access completes (0 = rejected)
        logic        exp_err;
        logic [31:0] exp_data;
        logic [15:0] exp_ddata;
    } vec_t;

    int checks   = 0;
    int failures = 0;
    vec_t tbl[$];

    function automatic vec_t mk(input string n, input logic e, input logic w, input logic g,
                                input logic [11:0] a, input logic [31:0] wd, input logic [31:0] rd,
                                input int ac, input int rc, input int bp, input int d,
                                input logic er, input logic [31:0] ed, input logic [15:0] edd);
        vec_t v;
        v.name = n; v.e32 = e; v.write = w; v.is_gpr = g; v.addr = a; v.wdata = wd;
        v.rdata = rd; v.ack_cyc = ac; v.res_cyc = rc; v.bp = bp; v.exp_d = d;
        v.exp_err = er; v.exp_data = ed; v.exp_ddata = edd;
        return v;
    endfunction

    // Reference model: decides the outcome from the request rules alone.
    function automatic void model(input vec_t v, output int d, output logic err,
                                  output logic [31:0] data, output logic [15:0] ddata);
        int  addr_i;
        logic illegal;
        addr_i  = int'(v.addr);
        illegal = v.is_gpr && (addr_i > 31 || (v.e32 && addr_i > 15));
        ddata   = v.is_gpr ? 16'(4096 + addr_i) : 16'(addr_i);
        if (illegal) begin
            d = 0; err = 1'b1; data = 32'd0;
        end else if (v.res_cyc >= v.ack_cyc && v.res_cyc <= TO + 1) begin
            d = v.res_cyc; err = 1'b0; data = v.write ? 32'd0 : v.rdata;
        end else begin
            d = TO + 1; err = 1'b1; data = 32'd0;
        end
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Entered at a negedge with the DUT idle; leaves at a negedge, idle again.
    task automatic run_txn(input vec_t v, input int d, input logic err,
                           input logic [31:0] data, input logic [15:0] ddata);
        int f0;
        f0 = failures;
        chk("req_ready_idle", 32'(bus.dbg_req_ready), 32'd1);
        e32                 = v.e32;
        bus.dbg_req_valid   = 1'b1;
        bus.dbg_req_write   = v.write;
        bus.dbg_req_is_gpr  = v.is_gpr;
        bus.dbg_req_address = v.addr;
        bus.dbg_req_data    = v.wdata;
        @(negedge clk);
        bus.dbg_req_valid = 1'b0;
        for (int c = 1; c <= d; c++) begin
            chk("instr_valid", 32'(bus.instruction__debug__valid), (c <= v.ack_cyc) ? 32'd1 : 32'd0);
            chk("resp_valid_busy", 32'(bus.dbg_resp_valid), 32'd0);
            chk("req_ready_busy", 32'(bus.dbg_req_ready), 32'd0);
            if (c == 1) begin
                chk("debug_op", 32'(bus.instruction__debug__debug_op), 32'(v.write));
                chk("debug_data", 32'(bus.instruction__debug__data), 32'(ddata));
                chk("instr_data", bus.instruction__data, v.write ? v.wdata : 32'd0);
            end
            bus.pipeline_debug_ack    = (c == v.ack_cyc);
            bus.pipeline_result_valid = (c == v.res_cyc);
            bus.pipeline_result_data  = v.rdata;
            @(negedge clk);
        end
        bus.pipeline_debug_ack    = 1'b0;
        bus.pipeline_result_valid = 1'b0;
        bus.pipeline_result_data  = $urandom;
        chk("resp_valid", 32'(bus.dbg_resp_valid), 32'd1);
        chk("resp_error", 32'(bus.dbg_resp_error), 32'(err));
        chk("resp_data", bus.dbg_resp_data, data);
        chk("instr_valid_resp", 32'(bus.instruction__debug__valid), 32'd0);
        chk("req_ready_resp", 32'(bus.dbg_req_ready), 32'd0);
        for (int b = 0; b < v.bp; b++) begin
            // A competing request must not be taken while the response waits.
            bus.dbg_req_valid   = 1'b1;
            bus.dbg_req_address = 12'($urandom);
            @(negedge clk);
            chk("resp_hold_valid", 32'(bus.dbg_resp_valid), 32'd1);
            chk("resp_hold_data", bus.dbg_resp_data, data);
            chk("resp_hold_error", 32'(bus.dbg_resp_error), 32'(err));
            chk("req_ready_hold", 32'(bus.dbg_req_ready), 32'd0);
            chk("instr_valid_hold", 32'(bus.instruction__debug__valid), 32'd0);
        end
        bus.dbg_resp_ready = 1'b1;
        @(negedge clk);
        bus.dbg_resp_ready = 1'b0;
        bus.dbg_req_valid  = 1'b0;
        chk("resp_valid_done", 32'(bus.dbg_resp_valid), 32'd0);
        chk("req_ready_done", 32'(bus.dbg_req_ready), 32'd1);
        chk("instr_valid_done", 32'(bus.instruction__debug__valid), 32'd0);
        $display("txn %-20s addr=0x%03h wr=%0b gpr=%0b e32=%0b done=%0d err=%0b data=0x%08h %s",
                 v.name, v.addr, v.write, v.is_gpr, v.e32, d, err, data,
                 (failures == f0) ? "ok" : "bad");
    endtask

    task automatic chk_all_reset(input string tag);
        chk({tag, "_req_ready"}, 32'(bus.dbg_req_ready), 32'd1);
        chk({tag, "_resp_valid"}, 32'(bus.dbg_resp_valid), 32'd0);
        chk({tag, "_resp_data"}, bus.dbg_resp_data, 32'd0);
        chk({tag, "_resp_error"}, 32'(bus.dbg_resp_error), 32'd0);
        chk({tag, "_instr_valid"}, 32'(bus.instruction__debug__valid), 32'd0);
        chk({tag, "_debug_op"}, 32'(bus.instruction__debug__debug_op), 32'd0);
        chk({tag, "_debug_data"}, 32'(bus.instruction__debug__data), 32'd0);
        chk({tag, "_instr_data"}, bus.instruction__data, 32'd0);
    endtask

    initial begin
        vec_t v;
        int   d;
        logic err;
        logic [31:0] data;
        logic [15:0] ddata;
        int   mode;

        bus.dbg_req_valid = 1'b0; bus.dbg_req_write = 1'b0; bus.dbg_req_is_gpr = 1'b0;
        bus.dbg_req_address = 12'd0; bus.dbg_req_data = 32'd0; bus.dbg_resp_ready = 1'b0;
        bus.pipeline_debug_ack = 1'b0; bus.pipeline_result_valid = 1'b0;
        bus.pipeline_result_data = 32'd0;

        //        name                 e32 wr gpr addr     wdata          rdata          ack    res    bp d  err data           ddata
        tbl.push_back(mk("csr_rd_300",        0, 0, 0, 12'h300, 32'h0,        32'hDEADBEEF, 3,     6,     5, 6, 0, 32'hDEADBEEF, 16'h0300));
        tbl.push_back(mk("gpr_wr_x5",         0, 1, 1, 12'h005, 32'h12345678, 32'hA5A5A5A5, 1,     1,     0, 1, 0, 32'h0,        16'h1005));
        tbl.push_back(mk("e32_gpr_x20",       1, 0, 1, 12'h014, 32'h0,        32'h0,        1,     1,     1, 0, 1, 32'h0,        16'h0000));
        tbl.push_back(mk("e32_gpr_x15",       1, 0, 1, 12'h00F, 32'h0,        32'h0BADF00D, 1,     2,     0, 2, 0, 32'h0BADF00D, 16'h100F));
        tbl.push_back(mk("gpr_addr_hi_bits",  0, 1, 1, 12'h025, 32'h1,        32'h0,        1,     1,     0, 0, 1, 32'h0,        16'h0000));
        tbl.push_back(mk("timeout_no_ack",    0, 0, 0, 12'h7C0, 32'h0,        32'h11111111, NEVER, NEVER, 2, 9, 1, 32'h0,        16'h07C0));
        tbl.push_back(mk("result_at_timeout", 0, 0, 0, 12'hB00, 32'h0,        32'hCAFEF00D, 2,     9,     0, 9, 0, 32'hCAFEF00D, 16'h0B00));
        tbl.push_back(mk("result_too_late",   0, 0, 1, 12'h01F, 32'h0,        32'h22222222, 2,     10,    0, 9, 1, 32'h0,        16'h101F));
        tbl.push_back(mk("result_before_ack", 0, 0, 0, 12'h341, 32'h0,        32'h33333333, 4,     2,     0, 9, 1, 32'h0,        16'h0341));
        tbl.push_back(mk("csr_wr_fff",        0, 1, 0, 12'hFFF, 32'hFFFFFFFF, 32'h44444444, 1,     3,     0, 3, 0, 32'h0,        16'h0FFF));
        tbl.push_back(mk("ack_at_timeout",    0, 1, 0, 12'h001, 32'h55,       32'h0,        9,     NEVER, 0, 9, 1, 32'h0,        16'h0001));
        tbl.push_back(mk("e32_gpr_x0",        1, 0, 1, 12'h000, 32'h0,        32'h00000066, 1,     1,     0, 1, 0, 32'h66,       16'h1000));

        repeat (2) @(negedge clk);
        chk_all_reset("rst");
        reset_n = 1'b1;
        @(negedge clk);

        foreach (tbl[i]) begin
            run_txn(tbl[i], tbl[i].exp_d, tbl[i].exp_err, tbl[i].exp_data, tbl[i].exp_ddata);
        end

        // Reset in the middle of an issue: no response must ever appear.
        e32 = 1'b0;
        bus.dbg_req_valid = 1'b1; bus.dbg_req_write = 1'b1; bus.dbg_req_is_gpr = 1'b0;
        bus.dbg_req_address = 12'h305; bus.dbg_req_data = 32'h89ABCDEF;
        @(negedge clk);
        bus.dbg_req_valid = 1'b0;
        chk("mid_issue_valid", 32'(bus.instruction__debug__valid), 32'd1);
        #2 reset_n = 1'b0;
        #1 chk_all_reset("async_rst");
        @(negedge clk);
        reset_n = 1'b1;
        // Stray ack/result while idle must be ignored.
        bus.pipeline_debug_ack = 1'b1; bus.pipeline_result_valid = 1'b1;
        bus.pipeline_result_data = 32'h77777777;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("post_rst_resp_valid", 32'(bus.dbg_resp_valid), 32'd0);
            chk("post_rst_req_ready", 32'(bus.dbg_req_ready), 32'd1);
            chk("post_rst_instr_valid", 32'(bus.instruction__debug__valid), 32'd0);
        end
        bus.pipeline_debug_ack = 1'b0; bus.pipeline_result_valid = 1'b0;
        $display("txn %-20s reset mid-issue, stray pipeline strobes in idle", "reset_mid_issue");

        for (int n = 0; n < 80; n++) begin
            v.name    = $sformatf("rand_%0d", n);
            v.e32     = 1'($urandom_range(0, 1));
            v.write   = 1'($urandom_range(0, 1));
            v.is_gpr  = 1'($urandom_range(0, 1));
            if (v.is_gpr && $urandom_range(0, 7) != 0) v.addr = 12'($urandom_range(0, 31));
            else                                       v.addr = 12'($urandom);
            v.wdata   = $urandom;
            v.rdata   = $urandom;
            v.ack_cyc = $urandom_range(1, 10);
            mode      = $urandom_range(0, 5);
            if (mode <= 3)      v.res_cyc = v.ack_cyc + $urandom_range(0, 3);
            else if (mode == 4) v.res_cyc = $urandom_range(1, v.ack_cyc);
            else                v.res_cyc = NEVER;
            v.bp      = $urandom_range(0, 3);
            model(v, d, err, data, ddata);
            run_txn(v, d, err, data, ddata);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

endmodule
